// File: rtl/core_run_controller_if.sv
// Program-load word stream between a boot source and core_run_controller.
// master drives words, slave (the controller) returns ready.
interface core_run_controller_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/core_run_controller.sv
// core_run_controller: boots the single-cycle RISC-V core. Streams a program
// into IMEM, holds the core in reset for one ARM cycle, runs it, and stops it
// on the halt instruction. Define CORE_WATCHDOG_EN to add a PC-stall watchdog
// that also halts the core and exposes o_wdt_timeout.
module core_run_controller #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = 32'h00000073,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned WDT_LIMIT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  core_run_controller_if.slave load,
  output logic                o_imem_we,
  output logic [ADDR_W-1:0]   o_imem_waddr,
  output logic [31:0]         o_imem_wdata,
  input  logic [31:0]         i_core_pc,
  input  logic [31:0]         i_core_instr,
  output logic                o_core_rst,
  output logic                o_core_en,
  output logic                o_halted,
  output logic                o_load_overflow,
  output logic [31:0]         o_halt_pc,
`ifdef CORE_WATCHDOG_EN
  output logic                o_wdt_timeout,
`endif
  output logic [CYC_W-1:0]    o_cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_HALT} state_t;

  if ((IMEM_DEPTH != (32'd1 << ADDR_W)) || (WDT_LIMIT == 0)) begin : g_param_check
    $error("core_run_controller: IMEM_DEPTH must equal 2**ADDR_W and WDT_LIMIT must be nonzero");
  end

  state_t              r_state, w_next_state;
  logic                r_load_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_waddr;
  logic [31:0]         r_imem_wdata;
  logic [ADDR_W-1:0]   r_count;
  logic                r_halted;
  logic                r_load_overflow;
  logic [31:0]         r_halt_pc;
  logic [CYC_W-1:0]    r_cycle_count;

  logic w_accept, w_last_slot, w_final, w_overflow;
  logic w_halt_instr, w_start_ok, w_wdt_hit;

  assign w_accept     = (r_state == S_LOAD) && r_load_ready && load.load_valid;
  assign w_last_slot  = (r_count == ADDR_W'(IMEM_DEPTH - 1));
  assign w_final      = w_accept && (load.load_last || w_last_slot);
  assign w_overflow   = w_accept && !load.load_last && w_last_slot;
  assign w_halt_instr = (i_core_instr == HALT_INSTR);
  assign w_start_ok   = i_start && (r_state inside {S_IDLE, S_RUN, S_HALT});

`ifdef CORE_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] r_stall;
  logic [31:0]      r_prev_pc;
  logic             r_wdt_timeout;

  assign w_wdt_hit = (r_state == S_RUN) && (i_core_pc == r_prev_pc) &&
                     (r_stall == WDT_W'(WDT_LIMIT - 1));

  // Stall counter: counts consecutive RUN cycles with an unchanged PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall       <= '0;
      r_prev_pc     <= '0;
      r_wdt_timeout <= 1'b0;
    end else begin
      r_prev_pc <= i_core_pc;
      if ((r_state == S_RUN) && !i_start && (i_core_pc == r_prev_pc))
        r_stall <= r_stall + 1'b1;
      else
        r_stall <= '0;
      if (w_start_ok)
        r_wdt_timeout <= 1'b0;
      else if (w_wdt_hit && !w_halt_instr)
        r_wdt_timeout <= 1'b1;
    end
  end

  assign o_wdt_timeout = r_wdt_timeout;
`else
  assign w_wdt_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and combinational core controls
  always_comb begin
    w_next_state = r_state;
    o_core_rst   = 1'b1;
    o_core_en    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = S_LOAD;
      S_LOAD: if (w_final) w_next_state = S_ARM;
      S_ARM:  w_next_state = S_RUN;
      S_RUN: begin
        o_core_rst = 1'b0;
        // Gating on the live instruction keeps the halt instruction from retiring.
        o_core_en  = !w_halt_instr;
        if (i_start)                       w_next_state = S_LOAD;
        else if (w_halt_instr || w_wdt_hit) w_next_state = S_HALT;
      end
      S_HALT: begin
        o_core_rst = 1'b0;
        if (i_start) w_next_state = S_LOAD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Load datapath, run cycle counting and halt capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_ready    <= 1'b0;
      r_imem_we       <= 1'b0;
      r_imem_waddr    <= '0;
      r_imem_wdata    <= '0;
      r_count         <= '0;
      r_halted        <= 1'b0;
      r_load_overflow <= 1'b0;
      r_halt_pc       <= '0;
      r_cycle_count   <= '0;
    end else begin
      r_load_ready <= (r_state == S_LOAD) && !w_final;
      r_imem_we    <= w_accept;
      if (w_accept) begin
        r_imem_waddr <= r_count;
        r_imem_wdata <= load.load_data;
        r_count      <= r_count + 1'b1;
      end
      if (w_overflow) r_load_overflow <= 1'b1;
      if (w_start_ok) begin
        r_count         <= '0;
        r_halted        <= 1'b0;
        r_load_overflow <= 1'b0;
        r_cycle_count   <= '0;
      end else if (r_state == S_RUN) begin
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
        if (w_halt_instr || w_wdt_hit) begin
          r_halted  <= 1'b1;
          r_halt_pc <= i_core_pc;
        end
      end
    end
  end

  assign load.load_ready  = r_load_ready;
  assign o_imem_we        = r_imem_we;
  assign o_imem_waddr     = r_imem_waddr;
  assign o_imem_wdata     = r_imem_wdata;
  assign o_halted         = r_halted;
  assign o_load_overflow  = r_load_overflow;
  assign o_halt_pc        = r_halt_pc;
  assign o_cycle_count    = r_cycle_count;

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
- Sequences the single-cycle RISC-V core: loads instruction memory from a word stream, releases the core, runs it and detects halt.
- Sits beside `riscv_single_cycle_processor` at SoC top.
- Drives the IMEM write port, core reset and core enable; exposes run status and a cycle counter.
- Replaces bench-side hex preloading for on-target boot.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two).
- ADDR_W, 8, IMEM word-address width (log2 IMEM_DEPTH).
- HALT_INSTR, 32'h00000073, instruction encoding treated as halt (ECALL).
- CYC_W, 32, cycle counter width.
- WDT_LIMIT, 1024, watchdog stall threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin load (honoured in IDLE, RUN, HALT).
- load_valid  in  1  load word valid.
- load_data  in  32  instruction word.
- load_last  in  1  marks final word of program.
- load_ready  out  1  controller accepts word.
- imem_we  out  1  IMEM write enable.
- imem_waddr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- core_pc  in  32  core current PC.
- core_instr  in  32  core current instruction.
- core_rst  out  1  reset to core, active-high.
- core_en  out  1  core PC/regfile/DMEM write enable.
- halted  out  1  core stopped on HALT_INSTR or watchdog.
- load_overflow  out  1  program exceeded IMEM_DEPTH.
- halt_pc  out  32  PC captured at halt.
- cycle_count  out  CYC_W  cycles spent in RUN.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, core_rst=1, core_en=0.
  - load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - halted=0, load_overflow=0, halt_pc=0, cycle_count=0, internal word count=0.
- rst asserted in any state, including mid-load or mid-run, returns to these values on the next edge. No partial write completes after that edge.
- States: IDLE, LOAD, ARM, RUN, HALT.
- IDLE:
  - core_rst=1.
  - start -> LOAD; clears count, halted, load_overflow, cycle_count.
- LOAD:
  - load_ready=1, registered (asserted the cycle after entry).
  - A word is accepted on load_valid && load_ready.
  - One cycle after acceptance: imem_we=1, imem_waddr=count, imem_wdata=load_data. Count then increments.
  - Accepting a word with load_last=1 -> ARM.
  - Accepting word IMEM_DEPTH-1 with load_last=0 -> ARM and load_overflow=1. Further words are not accepted.
  - load_ready is 0 from the cycle after the final acceptance.
  - start is ignored in LOAD.
- ARM:
  - Exactly one cycle; lets the final IMEM write land.
  - core_rst=1, then -> RUN.
- RUN:
  - core_rst=0; cycle_count increments each RUN cycle and saturates at all-ones.
  - core_en = (state==RUN) && (core_instr != HALT_INSTR). This is combinational, so the halt instruction never retires and the PC holds.
  - core_instr==HALT_INSTR at an edge -> HALT; halt_pc=core_pc.
  - start in RUN aborts: -> LOAD, core_rst=1 from the next cycle. Start takes priority over a simultaneous halt.
- HALT:
  - halted=1, core_en=0, core_rst=0 (core state preserved for inspection).
  - start -> LOAD.
- imem_we is never 1 outside the cycle after an accepted word.

Optional Feature:
- Macro: CORE_WATCHDOG_EN.
- Defined:
  - In RUN, a stall counter increments when core_pc equals its previous-cycle value and clears on any change.
  - Reaching WDT_LIMIT -> HALT with halted=1 and halt_pc=core_pc.
  - Catches "j ." self-loop termination.
  - Extra output wdt_timeout (1 bit, reset 0) is set on that transition and cleared on start.
- Not defined:
  - No counter and no stall-based halt.
  - wdt_timeout port is absent.

Test Plan:
- Reset then start; stream 4 words (0x00500093, 0x00A00113, 0x002081B3, 0x00000073, last on word 4) -> imem writes to addresses 0..3 with matching data, one cycle after each accept; ARM for 1 cycle; then core_rst=0.
- Program above runs -> halted=1 with halt_pc=0x0000000C; core_en=0 in the cycle core_instr=0x00000073; cycle_count=4.
- Stream IMEM_DEPTH words with load_last never set -> load_overflow=1, load_ready=0 after word 255, state ARM then RUN, no write to address 0 after wrap.
- Assert start while in RUN at cycle 2 -> core_rst=1 next cycle, load_ready=1 following cycle, cycle_count cleared to 0.
- Assert rst during LOAD after 2 words -> all outputs at reset values next edge; subsequent load_valid ignored until start.
- With CORE_WATCHDOG_EN, WDT_LIMIT=16, program 0x0000006F (j .) -> halted=1 and wdt_timeout=1 after 16 stalled cycles, halt_pc=0x00000000.
